// File: rtl/relu_layer_sequencer_if.sv
// Signal bundle for relu_layer_sequencer: the layer-side vector bus plus the
// go/done handshake to the shared ReLU unit. slave = sequencer, master = environment.
interface relu_layer_sequencer_if #(
  parameter int NEURON_NB = 10,
  parameter int WIDTH     = 32
);
  localparam int IDX_W = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1;

  logic                       layer_go;
  logic [WIDTH*NEURON_NB-1:0] data_in_array;
  logic                       layer_busy;
  logic                       layer_done;
  logic [WIDTH*NEURON_NB-1:0] data_out_array;
  logic                       err_timeout;
  logic                       relu_go;
  logic [WIDTH-1:0]           relu_data_in;
  logic [WIDTH-1:0]           relu_data_out;
  logic                       relu_done;
  logic [IDX_W-1:0]           neuron_idx;

  modport slave (
    input  layer_go, data_in_array, relu_data_out, relu_done,
    output layer_busy, layer_done, data_out_array, err_timeout,
           relu_go, relu_data_in, neuron_idx
  );

  modport master (
    output layer_go, data_in_array, relu_data_out, relu_done,
    input  layer_busy, layer_done, data_out_array, err_timeout,
           relu_go, relu_data_in, neuron_idx
  );
endinterface

// File: rtl/relu_layer_sequencer.sv
// Shares one ReLU unit across NEURON_NB neurons: captures the pre-activation
// vector, issues one go/done per neuron with a watchdog, assembles the result.
module relu_layer_sequencer #(
  parameter int NEURON_NB = 10,
  parameter int WIDTH     = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  relu_layer_sequencer_if.slave  bus
);
  localparam int IDX_W = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1;
  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NEURON_NB - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                         state_q, state_d;
  logic [NEURON_NB-1:0][WIDTH-1:0] buf_q;
  logic [NEURON_NB-1:0][WIDTH-1:0] out_q;
  logic [IDX_W-1:0]               idx_q;
  logic [WD_W-1:0]                wd_q;
  logic                           err_q;
  logic                           last_n;
  logic                           wd_expired;
  logic                           advance;

  always_comb begin
    last_n     = (idx_q == IDX_LAST);
    wd_expired = (wd_q == WD_MAX);
    advance    = (state_q == WAIT) && (bus.relu_done || wd_expired);
    state_d    = state_q;
    case (state_q)
      IDLE:    if (bus.layer_go) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (advance) state_d = last_n ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.layer_go) begin
          buf_q <= bus.data_in_array;
          idx_q <= '0;
          err_q <= 1'b0;
        end
        ISSUE: wd_q <= '0;
        WAIT: begin
          wd_q <= wd_q + 1'b1;
          if (advance) begin
            // A real result beats a coincident watchdog expiry.
            out_q[idx_q] <= bus.relu_done ? bus.relu_data_out : '0;
            if (!bus.relu_done) err_q <= 1'b1;
            if (!last_n) idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand comes straight from the captured buffer, so it stays stable through WAIT.
  assign bus.relu_data_in   = buf_q[idx_q];
  assign bus.relu_go        = (state_q == ISSUE);
  assign bus.layer_done     = (state_q == DONE);
  assign bus.layer_busy     = (state_q != IDLE);
  assign bus.neuron_idx     = idx_q;
  assign bus.data_out_array = out_q;
  assign bus.err_timeout    = err_q;
endmodule

// File: tb/tb_relu_layer_sequencer.sv
// Bench for relu_layer_sequencer: directed passes against a transaction-level
// model of the expected operand stream, output vector, error flag and latency.
module tb_relu_layer_sequencer;
  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  relu_layer_sequencer_if #(.NEURON_NB(N), .WIDTH(W)) bus ();

  relu_layer_sequencer #(.NEURON_NB(N), .WIDTH(W), .TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] relu(input logic [W-1:0] x);
    return x[W-1] ? '0 : x;
  endfunction

  // ReLU unit model: answers lat[idx] cycles after go (0 = never answers).
  int lat[N];
  int cnt = 0;
  logic [W-1:0] res;
  always @(posedge clk) begin
    logic s_go;
    logic [W-1:0] s_in;
    int s_idx;
    s_go  = bus.relu_go;
    s_in  = bus.relu_data_in;
    s_idx = int'(bus.neuron_idx);
    #1;
    bus.relu_done = 1'b0;
    if (!rst_n) begin
      cnt = 0;
      bus.relu_data_out = '0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.relu_done = 1'b1;
          bus.relu_data_out = res;
        end
      end
      if (s_go) begin
        res = relu(s_in);
        if (lat[s_idx] == 1) begin
          bus.relu_done = 1'b1;
          bus.relu_data_out = res;
        end else if (lat[s_idx] > 1) begin
          cnt = lat[s_idx] - 1;
        end
      end
    end
  end

  // Model state
  logic [W-1:0]   exp_ops[$];
  int             exp_ids[$];
  logic [W-1:0]   last_op = '0;
  logic [N*W-1:0] pass_vec = '0, idle_vec = '0;
  bit             pass_err = 0, idle_err = 0;
  int             done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.relu_go) begin
        if (exp_ops.size() == 0) begin
          chk("unexpected_relu_go", 32'd1, 32'd0);
        end else begin
          logic [W-1:0] op;
          int id;
          op = exp_ops.pop_front();
          id = exp_ids.pop_front();
          chk("relu_data_in", 32'(bus.relu_data_in), 32'(op));
          chk("neuron_idx", 32'(bus.neuron_idx), 32'(id));
          last_op = op;
        end
      end else if (bus.layer_busy) begin
        chk("relu_data_in_stable", 32'(bus.relu_data_in), 32'(last_op));
      end
      if (bus.layer_done) begin
        chk("out_vec_at_done", bus.data_out_array, pass_vec);
        chk("err_at_done", 32'(bus.err_timeout), 32'(pass_err));
        chk("ops_left_at_done", exp_ops.size(), 32'd0);
        chk("busy_in_done", 32'(bus.layer_busy), 32'd1);
        done_cnt++;
        idle_vec = pass_vec;
        idle_err = pass_err;
      end else if (!bus.layer_busy) begin
        chk("idle_out_vec", bus.data_out_array, idle_vec);
        chk("idle_err", 32'(bus.err_timeout), 32'(idle_err));
        chk("idle_relu_go", 32'(bus.relu_go), 32'd0);
      end
    end
  end

  // Loads expectations for one pass; returns the cycle layer_done should appear in.
  task automatic prep_model(input logic [N*W-1:0] vec, input int ls[N], output int exp_cycle);
    int total;
    bit timed;
    logic [W-1:0] op;
    total = 0;
    pass_vec = '0;
    pass_err = 0;
    for (int i = 0; i < N; i++) begin
      lat[i] = ls[i];
      op = vec[i*W +: W];
      exp_ops.push_back(op);
      exp_ids.push_back(i);
      timed = (ls[i] == 0) || (ls[i] > T);
      pass_vec[i*W +: W] = timed ? '0 : relu(op);
      if (timed) pass_err = 1;
      total += 1 + (timed ? T : ls[i]);
    end
    exp_cycle = total + 1;
  endtask

  task automatic run_pass(input string name, input logic [N*W-1:0] vec, input int ls[N],
                          input bit disturb, output int done_cycle);
    int exp_cycle, c, d0;
    prep_model(vec, ls, exp_cycle);
    d0 = done_cnt;
    @(negedge clk);
    bus.layer_go = 1'b1;
    bus.data_in_array = vec;
    @(negedge clk);
    bus.layer_go = 1'b0;
    c = 1;
    chk({name, "_busy"}, 32'(bus.layer_busy), 32'd1);
    chk({name, "_err_cleared"}, 32'(bus.err_timeout), 32'd0);
    while (!bus.layer_done && c < 100) begin
      if (disturb && c == 4) begin
        bus.layer_go = 1'b1;
        bus.data_in_array = ~vec;
      end
      if (disturb && c == 5) bus.layer_go = 1'b0;
      @(negedge clk);
      c++;
    end
    chk({name, "_done_cycle"}, c, exp_cycle);
    done_cycle = c;
    #1;
    if (disturb) begin
      repeat (6) @(negedge clk);
      chk({name, "_no_restart"}, 32'(bus.layer_busy), 32'd0);
    end
    chk({name, "_done_count"}, done_cnt - d0, 32'd1);
  endtask

  initial begin
    int dc, ec;
    int d0;
    bus.layer_go = 1'b0;
    bus.data_in_array = '0;
    for (int i = 0; i < N; i++) lat[i] = 1;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(bus.layer_busy), 32'd0);
    chk("rst_done", 32'(bus.layer_done), 32'd0);
    chk("rst_relu_go", 32'(bus.relu_go), 32'd0);
    chk("rst_err", 32'(bus.err_timeout), 32'd0);
    chk("rst_out", bus.data_out_array, 32'd0);
    chk("rst_relu_in", 32'(bus.relu_data_in), 32'd0);
    chk("rst_idx", 32'(bus.neuron_idx), 32'd0);
    #1 rst_n = 1'b1;

    // 1: single-cycle ReLU
    run_pass("t1", 32'h7F00F305, '{1, 1, 1, 1}, 0, dc);
    chk("t1_cycle_lit", dc, 32'd9);
    chk("t1_out_lit", bus.data_out_array, 32'h7F000005);
    chk("t1_err_lit", 32'(bus.err_timeout), 32'd0);

    // 2: three-cycle ReLU
    run_pass("t2", 32'h7F00F305, '{3, 3, 3, 3}, 0, dc);
    chk("t2_cycle_lit", dc, 32'd17);
    chk("t2_out_lit", bus.data_out_array, 32'h7F000005);

    // 3: neuron 2 never answers
    run_pass("t3", 32'h44332211, '{1, 1, 0, 1}, 0, dc);
    chk("t3_cycle_lit", dc, 32'd12);
    chk("t3_out_lit", bus.data_out_array, 32'h44002211);
    repeat (3) @(negedge clk);
    chk("t3_err_sticky_lit", 32'(bus.err_timeout), 32'd1);

    // 4: go while busy and input change mid-pass are ignored
    run_pass("t4", 32'h01020304, '{1, 2, 1, 1}, 1, dc);
    chk("t4_out_lit", bus.data_out_array, 32'h01020304);
    chk("t4_err_lit", 32'(bus.err_timeout), 32'd0);

    // 6: done coincides with watchdog expiry
    run_pass("t6", 32'hFF7E0180, '{1, 4, 1, 1}, 0, dc);
    chk("t6_cycle_lit", dc, 32'd12);
    chk("t6_out_lit", bus.data_out_array, 32'h007E0100);
    chk("t6_err_lit", 32'(bus.err_timeout), 32'd0);

    // 5: reset during WAIT of neuron 1
    prep_model(32'h10203040, '{1, 3, 1, 1}, ec);
    @(negedge clk);
    bus.layer_go = 1'b1;
    bus.data_in_array = 32'h10203040;
    @(negedge clk);
    bus.layer_go = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("t5_pre_busy", 32'(bus.layer_busy), 32'd1);
    chk("t5_pre_idx", 32'(bus.neuron_idx), 32'd1);
    #1 rst_n = 1'b0;
    exp_ops.delete();
    exp_ids.delete();
    idle_vec = '0;
    idle_err = 0;
    #1;
    chk("t5_rst_out", bus.data_out_array, 32'd0);
    chk("t5_rst_busy", 32'(bus.layer_busy), 32'd0);
    chk("t5_rst_done", 32'(bus.layer_done), 32'd0);
    chk("t5_rst_relu_go", 32'(bus.relu_go), 32'd0);
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 32'd0);
    run_pass("t5_after", 32'h7F00F305, '{1, 1, 1, 1}, 0, dc);
    chk("t5_after_out_lit", bus.data_out_array, 32'h7F000005);

    // back-to-back pass accepted in the cycle right after layer_done
    run_pass("b2b", 32'h807F0102, '{2, 1, 1, 2}, 0, dc);
    chk("b2b_out_lit", bus.data_out_array, 32'h007F0102);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/relu_layer_sequencer.md
Name: relu_layer_sequencer

Overview:
Time-multiplexes one shared ReLU unit across NEURON_NB neuron outputs, so a layer does not need NEURON_NB parallel ReLU instances.
- Accepts the flattened pre-activation vector from the dense-layer datapath.
- Issues one ReLU operation per neuron through a go/done handshake.
- Assembles the activated vector and pulses layer_done when all neurons are done.
- Sits between the neuron MAC array and the next layer's input register.

Parameters:
NEURON_NB, 10, number of neurons sequenced per layer pass
WIDTH, 32, bit width of each neuron value
TIMEOUT, 16, max cycles waited for relu_done per neuron before forcing progress (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
layer_go  input  1  start pulse; sampled only in IDLE
data_in_array  input  WIDTH*NEURON_NB  flattened pre-activations, neuron i at [(i+1)*WIDTH-1 -: WIDTH]
layer_busy  output  1  high in any state other than IDLE
layer_done  output  1  one-cycle pulse when the full output vector is valid
data_out_array  output  WIDTH*NEURON_NB  flattened activated outputs, same packing as input
err_timeout  output  1  sticky: some neuron timed out in the current/last pass
relu_go  output  1  one-cycle start strobe to the shared ReLU unit
relu_data_in  output  WIDTH  operand to the ReLU unit
relu_data_out  input  WIDTH  result from the ReLU unit
relu_done  input  1  result-valid strobe from the ReLU unit
neuron_idx  output  $clog2(NEURON_NB) (min 1)  index of the neuron in flight

Behaviour:
Reset (reset=0, asynchronous):
- State to IDLE.
- layer_busy, layer_done, relu_go, err_timeout = 0.
- data_out_array, relu_data_in, neuron_idx, input buffer, watchdog = 0.
- Reset asserted mid-pass aborts the pass immediately. No layer_done is produced.

FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, layer_go=1:
  - Capture data_in_array into the internal buffer.
  - idx=0, clear err_timeout, go to ISSUE.
  - layer_go=0: stay in IDLE.
- ISSUE:
  - relu_go=1 for exactly this cycle.
  - relu_data_in = buffer slice idx.
  - watchdog=0, go to WAIT.
- WAIT:
  - relu_go=0. relu_data_in is held stable.
  - Watchdog increments each cycle.
  - On relu_done=1: write relu_data_out into data_out_array slice idx. If idx==NEURON_NB-1 go to DONE; else idx+1, go to ISSUE.
  - If the watchdog reaches TIMEOUT-1 with relu_done=0: write 0 into slice idx, set err_timeout, then advance exactly as on done.
  - relu_done and timeout in the same cycle: relu_done wins; err_timeout is not set.
- DONE:
  - layer_done=1 for one cycle, then go to IDLE.
  - layer_busy stays high in DONE.

Handshake and ordering rules:
- layer_go while busy (ISSUE/WAIT/DONE) is ignored. It is not queued.
- data_in_array changes after capture have no effect on the current pass.
- relu_done outside WAIT is ignored.
- neuron_idx mirrors idx and is valid whenever busy.

Output visibility:
- data_out_array slices update progressively during a pass.
- The whole vector is guaranteed coherent only from the layer_done cycle until the next accepted layer_go.
- Slices not yet rewritten hold the previous pass's values.

Latency (ReLU unit with done one cycle after go):
- Go sampled at edge 0, then 2 cycles per neuron.
- layer_done is asserted in cycle 2*NEURON_NB+1.
- Next layer_go is accepted in the cycle after layer_done.

Test Plan:
1. NEURON_NB=4, WIDTH=8, 1-cycle ReLU model; inputs {0x05,0xF3,0x00,0x7F} (neuron0..3), layer_go -> exactly four relu_go pulses with relu_data_in 0x05,0xF3,0x00,0x7F; outputs {0x05,0x00,0x00,0x7F}; layer_done single pulse in cycle 9; err_timeout=0.
2. ReLU model with 3-cycle latency on the same vector -> same outputs; relu_data_in stable throughout each WAIT; layer_done in cycle 17.
3. TIMEOUT=4; model never answers for neuron 2 -> slice 2 = 0x00; err_timeout=1 after the pass and still 1 after layer_done; cleared by the next layer_go.
4. layer_go pulsed during WAIT, and data_in_array changed mid-pass -> no restart; results reflect the originally captured vector; one layer_done only.
5. reset driven low during WAIT of neuron 1 -> outputs immediately 0, layer_busy=0, no layer_done; after release a new layer_go completes normally.
6. relu_done coinciding with the watchdog reaching TIMEOUT-1 -> relu_data_out stored; err_timeout stays 0.
